// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and types for the fetch stage
// Purpose: bubble word, default reset PC, fetch state encoding and the
//          opcode values the decoder uses for HALT and J.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OPC_HALT = 6'b111111;
  localparam logic [5:0] OPC_J    = 6'b000010;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with enable and bubble
// Purpose: holds the fetched instruction, its PC+4 and a valid flag for decode.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                load instr_in/pc_plus4_in (valid=1) on the edge
//   bubble            load a bubble (NOP, 0, valid=0); overrides en
//   instr_in          instruction word from instruction memory
//   pc_plus4_in       PC+4 of that instruction
//   instr_out         registered instruction
//   pc_plus4_out      registered PC+4
//   valid_out         1 = real instruction, 0 = bubble
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   bubble,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_plus4_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    pc_plus4_out,
  output logic                   valid_out
);

  localparam logic [INSTR_WIDTH-1:0] BUBBLE_INSTR = INSTR_WIDTH'(NOP_INSTR);

  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]    ifid_pc4_q, ifid_pc4_d;
  logic                   ifid_valid_q, ifid_valid_d;

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    // Bubble wins over enable so a flush still lands while the stage is stalled.
    if (bubble) begin
      ifid_instr_d = BUBBLE_INSTR;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (en) begin
      ifid_instr_d = instr_in;
      ifid_pc4_d   = pc_plus4_in;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr_q <= BUBBLE_INSTR;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign instr_out    = ifid_instr_q;
  assign pc_plus4_out = ifid_pc4_q;
  assign valid_out    = ifid_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage with HALT freeze
// Purpose: PC register, next-PC selection (sequential/branch/jump), RUN/HALTED
//          state machine and the IF/ID register feeding decode.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_addr / imem_rdata   instruction-memory address (= PC) and read data
//   stall_f, flush_d         hazard-unit stall and IF/ID flush
//   pcsrc_d, pc_branch_d     taken branch and its target
//   jump_d, pc_jump_d        jump and its target
//   pc_load_d                0 = HALT opcode sitting in decode
//   instr_d, pc_plus4_d, valid_d   IF/ID contents
//   halted                   fetch frozen until reset
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                   PC_WIDTH    = 32,
  parameter int                   INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall_f,
  input  logic                   flush_d,
  input  logic                   pcsrc_d,
  input  logic [PC_WIDTH-1:0]    pc_branch_d,
  input  logic                   jump_d,
  input  logic [PC_WIDTH-1:0]    pc_jump_d,
  input  logic                   pc_load_d,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [PC_WIDTH-1:0]    pc_plus4_d,
  output logic                   valid_d,
  output logic                   halted
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                halt_evt;
  logic                ifid_en;
  logic                ifid_bubble;

  assign pc_plus4 = pc_q + PC_STEP;

  // A bubble in decode carries no opcode, so pc_load_d only counts when valid.
  assign halt_evt = (state_q == RUN) & valid_d & ~pc_load_d & ~stall_f;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_en     = 1'b0;
    ifid_bubble = 1'b0;
    // HALTED falls through the defaults: PC and IF/ID frozen, all inputs ignored.
    if (state_q == RUN) begin
      if (stall_f) begin
        ifid_bubble = flush_d;
      end else if (halt_evt) begin
        state_d     = HALTED;
        ifid_bubble = 1'b1;
      end else begin
        ifid_en     = 1'b1;
        ifid_bubble = flush_d;
        if (jump_d) begin
          pc_d = pc_jump_d & ALIGN_MASK;
        end else if (pcsrc_d) begin
          pc_d = pc_branch_d & ALIGN_MASK;
        end else begin
          pc_d = pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk          (clk),
    .rst          (rst),
    .en           (ifid_en),
    .bubble       (ifid_bubble),
    .instr_in     (imem_rdata),
    .pc_plus4_in  (pc_plus4),
    .instr_out    (instr_d),
    .pc_plus4_out (pc_plus4_d),
    .valid_out    (valid_d)
  );

  assign imem_addr = pc_q;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] ADDI_WORD = 32'h2008_0005;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_f;
  logic        flush_d;
  logic        pcsrc_d;
  logic [31:0] pc_branch_d;
  logic        jump_d;
  logic [31:0] pc_jump_d;
  logic        pc_load_d;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        halted;

  logic        const_mode;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halted;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall_f     (stall_f),
    .flush_d     (flush_d),
    .pcsrc_d     (pcsrc_d),
    .pc_branch_d (pc_branch_d),
    .jump_d      (jump_d),
    .pc_jump_d   (pc_jump_d),
    .pc_load_d   (pc_load_d),
    .instr_d     (instr_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (const_mode) return ADDI_WORD;
    return a * 32'h9E37_79B1 + 32'h1;
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".instr_d"}, instr_d, m_instr);
    chk({tag, ".pc_plus4_d"}, pc_plus4_d, m_pc4);
    chk({tag, ".valid_d"}, {31'b0, valid_d}, {31'b0, m_valid});
    chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP_INSTR; m_pc4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // Reference: compute the next visible state from the current inputs, then clock.
  task automatic tick(input string tag);
    logic [31:0] n_pc, n_instr, n_pc4;
    logic        n_valid, n_halted, to_bubble, to_load;
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid; n_halted = m_halted;
    to_bubble = 1'b0; to_load = 1'b0;
    if (!m_halted) begin
      if (stall_f) begin
        to_bubble = flush_d;
      end else if (m_valid && !pc_load_d) begin
        to_bubble = 1'b1;
        n_halted  = 1'b1;
      end else begin
        to_bubble = flush_d;
        to_load   = !flush_d;
        if (jump_d)       n_pc = pc_jump_d - (pc_jump_d % 4);
        else if (pcsrc_d) n_pc = pc_branch_d - (pc_branch_d % 4);
        else              n_pc = m_pc + 32'd4;
      end
    end
    if (to_bubble) begin
      n_instr = NOP_INSTR; n_pc4 = 32'h0; n_valid = 1'b0;
    end else if (to_load) begin
      n_instr = imem_word(m_pc); n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid; m_halted = n_halted;
    check_all(tag);
  endtask

  // Called 1 time unit after an edge: pulses rst well away from any clock edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  task automatic idle_inputs();
    stall_f = 1'b0; flush_d = 1'b0; pcsrc_d = 1'b0; jump_d = 1'b0;
    pc_load_d = 1'b1; pc_branch_d = 32'h0; pc_jump_d = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    const_mode = 1'b1;
    idle_inputs();
    #2;
    model_reset();
    check_all("reset");
    chk("reset.addr_const", imem_addr, 32'h0);
    #1 rst = 1'b0;

    tick("run1");
    chk("run1.instr_const", instr_d, ADDI_WORD);
    chk("run1.pc4_const", pc_plus4_d, 32'h4);
    tick("run2");
    chk("run2.addr_const", imem_addr, 32'h8);

    stall_f = 1'b1;
    tick("stall1");
    tick("stall2");
    chk("stall2.addr_const", imem_addr, 32'h8);
    chk("stall2.pc4_const", pc_plus4_d, 32'h8);
    stall_f = 1'b0;
    tick("resume");
    chk("resume.addr_const", imem_addr, 32'hC);

    jump_d = 1'b1; pcsrc_d = 1'b1; flush_d = 1'b1;
    pc_jump_d = 32'h100; pc_branch_d = 32'h200;
    tick("jmp_br_flush");
    chk("jmp_br_flush.addr_const", imem_addr, 32'h100);
    chk("jmp_br_flush.valid_const", {31'b0, valid_d}, 32'h0);
    idle_inputs();

    const_mode = 1'b0;
    pcsrc_d = 1'b1; pc_branch_d = 32'h43;
    tick("branch_align");
    chk("branch_align.addr_const", imem_addr, 32'h40);
    idle_inputs();
    jump_d = 1'b1; pc_jump_d = 32'hFFFF_FFFE;
    tick("jump_top");
    idle_inputs();
    tick("wrap");
    chk("wrap.addr_const", imem_addr, 32'h0);
    chk("wrap.pc4_const", pc_plus4_d, 32'h0);

    jump_d = 1'b1; pc_jump_d = 32'h10;
    tick("to_10");
    idle_inputs();
    tick("to_14");
    pc_load_d = 1'b0;
    tick("halt");
    chk("halt.addr_const", imem_addr, 32'h14);
    chk("halt.halted_const", {31'b0, halted}, 32'h1);
    chk("halt.valid_const", {31'b0, valid_d}, 32'h0);
    pc_load_d = 1'b1; jump_d = 1'b1; pc_jump_d = 32'h80; flush_d = 1'b1; pcsrc_d = 1'b1;
    tick("halted_jump");
    chk("halted_jump.addr_const", imem_addr, 32'h14);
    idle_inputs();
    async_reset("areset");
    chk("areset.addr_const", imem_addr, 32'h0);
    chk("areset.halted_const", {31'b0, halted}, 32'h0);
    tick("after_reset");
    chk("after_reset.addr_const", imem_addr, 32'h4);

    for (int i = 0; i < 400; i++) begin
      stall_f     = ($urandom_range(0, 99) < 25);
      flush_d     = ($urandom_range(0, 99) < 15);
      pcsrc_d     = ($urandom_range(0, 99) < 20);
      jump_d      = ($urandom_range(0, 99) < 10);
      pc_load_d   = ($urandom_range(0, 99) >= 4);
      pc_branch_d = $urandom;
      pc_jump_d   = $urandom;
      tick("rand");
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0)
        async_reset("rand_areset");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core, directly upstream of the decode stage and its main control decoder.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from sequential, branch and jump sources.
- Owns the IF/ID pipeline register and reacts to the decoder's halt indication (pc_load_d=0) by freezing fetch permanently until reset.

Parameters:
- PC_WIDTH, 32, width of PC and all address ports
- INSTR_WIDTH, 32, instruction word width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  PC_WIDTH  instruction-memory address (equals current PC)
- imem_rdata  in  INSTR_WIDTH  instruction word; combinational read of imem_addr
- stall_f  in  1  hazard-unit stall; holds PC and IF/ID register
- flush_d  in  1  converts IF/ID contents to a bubble
- pcsrc_d  in  1  branch taken, resolved in decode
- pc_branch_d  in  PC_WIDTH  branch target
- jump_d  in  1  jump, from decoder
- pc_jump_d  in  PC_WIDTH  jump target
- pc_load_d  in  1  decoder load signal; 0 = HALT opcode in decode
- instr_d  out  INSTR_WIDTH  IF/ID instruction
- pc_plus4_d  out  PC_WIDTH  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction (0 = bubble)
- halted  out  1  fetch frozen by HALT

Behaviour:
- Reset (async, rst=1): PC=RESET_PC, instr_d=32'h0 (NOP), pc_plus4_d=0, valid_d=0, halted=0, state=RUN.
- Reset mid-operation discards all in-flight state immediately, without waiting for a clock edge.
- Latency: instruction at PC appears on instr_d one cycle after imem_addr=PC (single registered stage).
- Arithmetic: pc_plus4 = PC+4, modulo 2^PC_WIDTH. 0xFFFF_FFFC wraps to 0x0000_0000.
- Target alignment: bits [1:0] of pc_branch_d and pc_jump_d are forced to 0 before loading the PC.
- State machine has two states: RUN and HALTED.
- RUN next-PC priority, evaluated each edge:
  - 1) stall_f=1: PC held, IF/ID held, except that flush_d=1 still bubbles IF/ID.
  - 2) halt_evt = valid_d & ~pc_load_d & ~stall_f: PC held, IF/ID <- bubble, state -> HALTED, halted=1 next cycle.
  - 3) jump_d=1: PC <- pc_jump_d.
  - 4) pcsrc_d=1: PC <- pc_branch_d.
  - 5) otherwise: PC <- PC+4.
- If jump_d and pcsrc_d are both 1, jump wins.
- IF/ID load in RUN without stall:
  - flush_d=1 or halt_evt: loads bubble (instr 0, valid 0, pc_plus4 0).
  - Otherwise: loads {imem_rdata, PC+4, valid=1}.
- flush_d has priority over stall_f for IF/ID only. PC obeys stall_f regardless of flush_d.
- Bubble word 0 decodes as R-type sll $0, which is architecturally harmless.
- pc_load_d is ignored while valid_d=0, so a bubble never triggers a halt.
- HALTED: PC frozen, IF/ID held as bubble. stall_f, flush_d, pcsrc_d and jump_d are all ignored. The only exit is rst.
- imem_addr is always the current PC register, including while stalled or halted.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'h0000_0000
  - RESET_PC default
  - fetch state enum {RUN, HALTED}
  - opcode constants (HALT = 6'b111111, J = 6'b000010) for bench reuse
- One natural sub-module: if_id_reg. It is the pipeline register with enable (~stall), synchronous bubble (flush), async reset, and carries instr/pc_plus4/valid.
- PC register, next-PC mux and state machine stay in fetch_stage.

Test Plan:
- Reset then free-run 4 cycles with imem returning 0x2008_0005 (addi): imem_addr goes 0,4,8,C; instr_d=0x2008_0005 and valid_d=1 from cycle 1; pc_plus4_d=4,8,C.
- stall_f=1 for 2 cycles at PC=0x8: imem_addr stays 0x8 and instr_d/pc_plus4_d are unchanged; after release PC resumes 0xC.
- jump_d=1, pcsrc_d=1 in the same cycle, pc_jump_d=0x100, pc_branch_d=0x200: next imem_addr=0x100. Concurrent flush_d=1 gives instr_d=0, valid_d=0.
- pc_branch_d=0x43 with pcsrc_d=1: PC=0x40. Separately, from PC=0xFFFF_FFFC sequential fetch: next PC=0x0, pc_plus4_d=0x0.
- HALT in decode (valid_d=1, pc_load_d=0) at PC=0x14: PC stays 0x14 and halted=1 next cycle, valid_d=0. Subsequent jump_d=1 to 0x80 leaves PC=0x14.
- Assert rst asynchronously mid-cycle while HALTED at PC=0x14: PC=RESET_PC and halted=0 immediately, before the next edge; fetch resumes from 0x0 after release.
